// File: rtl/motor_pkg.sv
// Shared types and constants for the two-channel H-bridge PWM driver.
package motor_pkg;

  localparam int SPEED_W = 14;
  localparam int DEAD_W  = 4;

  localparam int PERIOD_DEFAULT       = 12500;
  localparam int DEAD_PERIODS_DEFAULT = 2;

  // Bit positions inside the {lv4, lv3, lv2, lv1} pin vector
  localparam int FWD_IDX_L = 0;
  localparam int BWD_IDX_L = 1;
  localparam int BWD_IDX_R = 2;
  localparam int FWD_IDX_R = 3;

  typedef enum logic {
    CH_RUN  = 1'b0,
    CH_DEAD = 1'b1
  } ch_state_t;

  function automatic logic [SPEED_W-1:0] clamp_duty(input logic [SPEED_W-1:0] speed,
                                                     input logic [SPEED_W-1:0] period);
    return (speed > period) ? period : speed;
  endfunction

endpackage

// File: rtl/motor_channel.sv
// One bridge side: command shadows, duty compare, RUN/DEAD coast FSM and
// registered forward/backward pins.
//   state   | meaning
//   CH_RUN  | pins follow PWM on the active direction's pin
//   CH_DEAD | both pins low, counting coast periods
module motor_channel
  import motor_pkg::*;
#(
  parameter int PERIOD       = PERIOD_DEFAULT,
  parameter int DEAD_PERIODS = DEAD_PERIODS_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SPEED_W-1:0] cnt,
  input  logic               boundary,
  input  logic [SPEED_W-1:0] speed,
  input  logic               dir,
  input  logic               en,
  output logic               fwd,
  output logic               bwd
);

  localparam logic [SPEED_W-1:0] PERIOD_V    = SPEED_W'(PERIOD);
  localparam logic [DEAD_W-1:0]  DEAD_RELOAD = DEAD_W'(DEAD_PERIODS - 1);

  ch_state_t          state, state_nxt;
  logic [DEAD_W-1:0]  dead_cnt, dead_nxt;
  logic [SPEED_W-1:0] duty;
  logic               dir_act;
  logic               en_sh;
  logic               drive;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= CH_RUN;
      dead_cnt <= '0;
      duty     <= '0;
      dir_act  <= 1'b1;
      en_sh    <= 1'b1;
      fwd      <= 1'b0;
      bwd      <= 1'b0;
    end else begin
      state    <= state_nxt;
      dead_cnt <= dead_nxt;
      if (boundary) begin
        duty    <= clamp_duty(speed, PERIOD_V);
        dir_act <= dir;
        en_sh   <= en;
      end
      // Gated by one shared term, so fwd and bwd can never be high together
      fwd <= drive & dir_act;
      bwd <= drive & ~dir_act;
    end
  end

  always_comb begin
    state_nxt = state;
    dead_nxt  = dead_cnt;
    if (boundary) begin
      // Disable, the first enabled boundary after a disable, and reversals
      // all restart the full coast time.
      if (!en || !en_sh || (dir != dir_act)) begin
        state_nxt = CH_DEAD;
        dead_nxt  = DEAD_RELOAD;
      end else if (state == CH_DEAD) begin
        if (dead_cnt == '0) begin
          state_nxt = CH_RUN;
        end else begin
          dead_nxt = dead_cnt - DEAD_W'(1);
        end
      end
    end
    drive = en && (state == CH_RUN) && (cnt < duty);
  end

endmodule

// File: rtl/motor_pwm_driver.sv
// Dual H-bridge PWM driver: shared period counter, period_start pulse and
// mapping of the two channels onto LV1..LV4.
module motor_pwm_driver
  import motor_pkg::*;
#(
  parameter int PERIOD       = PERIOD_DEFAULT,
  parameter int DEAD_PERIODS = DEAD_PERIODS_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [SPEED_W-1:0] speed_l,
  input  logic               dir_l,
  input  logic [SPEED_W-1:0] speed_r,
  input  logic               dir_r,
  output logic               lv1,
  output logic               lv2,
  output logic               lv3,
  output logic               lv4,
  output logic               period_start
);

  localparam logic [SPEED_W-1:0] CNT_LAST = SPEED_W'(PERIOD - 1);

  logic [SPEED_W-1:0] cnt;
  logic               boundary;
  logic               fwd_l, bwd_l, fwd_r, bwd_r;
  logic [3:0]         lv;

  assign boundary = (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      cnt          <= boundary ? '0 : cnt + SPEED_W'(1);
      // Registered alongside the pins, so it marks the cycle showing cnt=0
      period_start <= (cnt == '0);
    end
  end

  motor_channel #(
    .PERIOD       (PERIOD),
    .DEAD_PERIODS (DEAD_PERIODS)
  ) u_chan_l (
    .clk      (clk),
    .rst      (rst),
    .cnt      (cnt),
    .boundary (boundary),
    .speed    (speed_l),
    .dir      (dir_l),
    .en       (en),
    .fwd      (fwd_l),
    .bwd      (bwd_l)
  );

  motor_channel #(
    .PERIOD       (PERIOD),
    .DEAD_PERIODS (DEAD_PERIODS)
  ) u_chan_r (
    .clk      (clk),
    .rst      (rst),
    .cnt      (cnt),
    .boundary (boundary),
    .speed    (speed_r),
    .dir      (dir_r),
    .en       (en),
    .fwd      (fwd_r),
    .bwd      (bwd_r)
  );

  always_comb begin
    lv            = '0;
    lv[FWD_IDX_L] = fwd_l;
    lv[BWD_IDX_L] = bwd_l;
    lv[FWD_IDX_R] = fwd_r;
    lv[BWD_IDX_R] = bwd_r;
  end

  assign lv1 = lv[0];
  assign lv2 = lv[1];
  assign lv3 = lv[2];
  assign lv4 = lv[3];

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Directed bench for motor_pwm_driver with PERIOD=100, DEAD_PERIODS=2.
module tb_motor_pwm_driver;

  logic        clk;
  logic        rst;
  logic        en;
  logic [13:0] speed_l;
  logic        dir_l;
  logic [13:0] speed_r;
  logic        dir_r;
  logic        lv1, lv2, lv3, lv4;
  logic        period_start;

  int total   = 0;
  int bad     = 0;
  int inv_bad = 0;

  int cnt_pin[4];
  int cnt_ps;
  int shape_bad;

  typedef struct {
    logic            en;
    logic [13:0]     sl;
    logic            dl;
    logic [13:0]     sr;
    logic            dr;
    logic [2:0][31:0] exp;   // per period after sampling: {lv1,lv2,lv3,lv4} high counts
  } vec_t;

  localparam int NVEC = 13;
  vec_t tbl[NVEC];

  motor_pwm_driver #(
    .PERIOD       (100),
    .DEAD_PERIODS (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .speed_l      (speed_l),
    .dir_l        (dir_l),
    .speed_r      (speed_r),
    .dir_r        (dir_r),
    .lv1          (lv1),
    .lv2          (lv2),
    .lv3          (lv3),
    .lv4          (lv4),
    .period_start (period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if ((lv1 && lv2) || (lv3 && lv4)) begin
      inv_bad++;
      $display("FAIL shoot_through at %0t: lv1=%0b lv2=%0b lv3=%0b lv4=%0b", $time, lv1, lv2, lv3, lv4);
    end
  end

  function automatic logic [31:0] cn(int a, int b, int c, int d);
    return {8'(a), 8'(b), 8'(c), 8'(d)};
  endfunction

  function automatic vec_t mk(logic e, int sl, logic dl, int sr, logic dr,
                              logic [31:0] pa, logic [31:0] pb, logic [31:0] pc);
    vec_t t;
    t.en     = e;
    t.sl     = 14'(sl);
    t.dl     = dl;
    t.sr     = 14'(sr);
    t.dr     = dr;
    t.exp[0] = pa;
    t.exp[1] = pb;
    t.exp[2] = pc;
    return t;
  endfunction

  task automatic check(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic sync_ps();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (period_start) begin
        found = 1'b1;
        break;
      end
    end
    check("period_start_seen", int'(found), 1);
  endtask

  // Starts on a period_start cycle and spans the 100 cycles of that output period
  task automatic count_period();
    logic [3:0] p;
    logic [3:0] low_seen;
    low_seen = '0;
    for (int k = 0; k < 4; k++) cnt_pin[k] = 0;
    cnt_ps    = 0;
    shape_bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (i != 0) @(negedge clk);
      p = {lv4, lv3, lv2, lv1};
      for (int k = 0; k < 4; k++) begin
        if (p[k]) begin
          cnt_pin[k]++;
          if (low_seen[k]) shape_bad = 1;
        end else begin
          low_seen[k] = 1'b1;
        end
      end
      cnt_ps += int'(period_start);
    end
  endtask

  task automatic measure();
    sync_ps();
    count_period();
  endtask

  initial begin
    tbl[0]  = mk(1,    40, 1,   0, 1, cn(40,0,0,0),   cn(40,0,0,0),   cn(40,0,0,0));
    tbl[1]  = mk(1,    40, 1, 250, 1, cn(40,0,0,100), cn(40,0,0,100), cn(40,0,0,100));
    tbl[2]  = mk(1,    40, 1,   0, 1, cn(40,0,0,0),   cn(40,0,0,0),   cn(40,0,0,0));
    tbl[3]  = mk(1,    60, 0,   0, 1, cn(0,0,0,0),    cn(0,0,0,0),    cn(0,60,0,0));
    tbl[4]  = mk(1,    60, 0, 100, 0, cn(0,60,0,0),   cn(0,60,0,0),   cn(0,60,100,0));
    tbl[5]  = mk(1,     1, 0,  99, 0, cn(0,1,99,0),   cn(0,1,99,0),   cn(0,1,99,0));
    tbl[6]  = mk(1, 16383, 1, 100, 1, cn(0,0,0,0),    cn(0,0,0,0),    cn(100,0,0,100));
    tbl[7]  = mk(0, 16383, 1, 100, 1, cn(0,0,0,0),    cn(0,0,0,0),    cn(0,0,0,0));
    tbl[8]  = mk(1, 16383, 1, 100, 1, cn(0,0,0,0),    cn(0,0,0,0),    cn(100,0,0,100));
    tbl[9]  = mk(0, 16383, 0, 100, 1, cn(0,0,0,0),    cn(0,0,0,0),    cn(0,0,0,0));
    tbl[10] = mk(1, 16383, 0, 100, 1, cn(0,0,0,0),    cn(0,0,0,0),    cn(0,100,0,100));
    tbl[11] = mk(1,   100, 0,   0, 1, cn(0,100,0,0),  cn(0,100,0,0),  cn(0,100,0,0));
    tbl[12] = mk(1,    60, 1,   0, 1, cn(0,0,0,0),    cn(0,0,0,0),    cn(60,0,0,0));

    // Reset state
    rst = 1'b0; en = 1'b0; speed_l = '0; speed_r = '0; dir_l = 1'b1; dir_r = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst lv1", int'(lv1), 0);
    check("rst lv2", int'(lv2), 0);
    check("rst lv3", int'(lv3), 0);
    check("rst lv4", int'(lv4), 0);
    check("rst period_start", int'(period_start), 0);

    // First periods after reset: shadow duty 0, then 40/100 edge-aligned
    en = 1'b1; speed_l = 14'd40; rst = 1'b1;
    sync_ps();
    count_period();
    check("first period lv1", cnt_pin[0], 0);
    @(negedge clk);
    check("ps spacing 1", int'(period_start), 1);
    check("lv1 rises with ps", int'(lv1), 1);
    count_period();
    check("duty40 lv1", cnt_pin[0], 40);
    check("duty40 lv2", cnt_pin[1], 0);
    check("duty40 ps pulses", cnt_ps, 1);
    check("duty40 lv1 low at period end", int'(lv1), 0);
    @(negedge clk);
    check("ps spacing 2", int'(period_start), 1);

    // Table: apply at a period start, check the three following periods
    for (int r = 0; r < NVEC; r++) begin
      sync_ps();
      en = tbl[r].en; speed_l = tbl[r].sl; dir_l = tbl[r].dl;
      speed_r = tbl[r].sr; dir_r = tbl[r].dr;
      for (int pp = 0; pp < 3; pp++) begin
        measure();
        for (int k = 0; k < 4; k++)
          check($sformatf("row%0d p%0d lv%0d", r, pp, k + 1), cnt_pin[k],
                int'(tbl[r].exp[pp][8*(3-k) +: 8]));
        check($sformatf("row%0d p%0d ps", r, pp), cnt_ps, 1);
        check($sformatf("row%0d p%0d shape", r, pp), shape_bad, 0);
      end
    end

    // Reversal and reversal-back during the first dead period restarts dead time
    sync_ps();
    dir_l = 1'b0;
    sync_ps();
    dir_l = 1'b1;
    count_period();
    check("rerev dead1 lv1", cnt_pin[0], 0);
    check("rerev dead1 lv2", cnt_pin[1], 0);
    measure();
    check("rerev dead2 lv1", cnt_pin[0], 0);
    check("rerev dead2 lv2", cnt_pin[1], 0);
    measure();
    check("rerev dead3 lv1", cnt_pin[0], 0);
    check("rerev dead3 lv2", cnt_pin[1], 0);
    measure();
    check("rerev run lv1", cnt_pin[0], 60);
    check("rerev run lv2", cnt_pin[1], 0);

    // en dropped at cnt=30 with duty 70, restored after one disabled boundary
    sync_ps();
    speed_l = 14'd70;
    measure();
    check("en pre lv1", cnt_pin[0], 70);
    sync_ps();
    repeat (29) @(negedge clk);
    check("en pre-drop lv1", int'(lv1), 1);
    en = 1'b0;
    @(negedge clk);
    check("en drop lv1", int'(lv1), 0);
    check("en drop pins", int'({lv1, lv2, lv3, lv4}), 0);
    begin
      int hi;
      bit found;
      hi = 0; found = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (period_start) begin
          found = 1'b1;
          break;
        end
        if (lv1 || lv2 || lv3 || lv4) hi++;
      end
      check("en off rest highs", hi, 0);
      check("en off ps seen", int'(found), 1);
    end
    en = 1'b1;
    count_period();
    check("en back p0 lv1", cnt_pin[0], 0);
    measure();
    check("en back dead1 lv1", cnt_pin[0], 0);
    measure();
    check("en back dead2 lv1", cnt_pin[0], 0);
    measure();
    check("en back run lv1", cnt_pin[0], 70);
    check("en back run lv2", cnt_pin[1], 0);

    // Reset pulse at cnt=50 during 100% duty
    sync_ps();
    speed_l = 14'd100;
    measure();
    check("full duty lv1", cnt_pin[0], 100);
    sync_ps();
    repeat (49) @(negedge clk);
    check("pre-rst lv1", int'(lv1), 1);
    rst = 1'b0;
    @(negedge clk);
    check("rst mid lv1", int'(lv1), 0);
    check("rst mid pins", int'({lv1, lv2, lv3, lv4}), 0);
    check("rst mid ps", int'(period_start), 0);
    rst = 1'b1;
    @(negedge clk);
    check("post-rst ps restart", int'(period_start), 1);
    count_period();
    check("post-rst zero duty lv1", cnt_pin[0], 0);
    measure();
    check("post-rst resampled lv1", cnt_pin[0], 100);
    check("post-rst resampled lv2", cnt_pin[1], 0);

    check("no shoot-through", inv_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
